// File: rtl/restoring_divider_seq.sv
// Sequential unsigned restoring divider that resolves one quotient bit per clock.
// Optional macro DIV_ZERO_FAST_EN: a zero divisor finishes one edge after acceptance.

module subtractor_lookahead #(
    parameter int SIZE = 6
) (
    input  logic [SIZE-1:0] a_i,
    input  logic [SIZE-1:0] b_i,
    output logic [SIZE-1:0] diff_o,
    output logic            borrowOut_o
);

    logic [SIZE-1:0] gen;
    logic [SIZE-1:0] prop;
    logic [SIZE:0]   carry;
    logic            term;

    // a - b as a + ~b + 1; carry out of the top bit means no borrow occurred
    assign gen  = a_i & ~b_i;
    assign prop = a_i ^ ~b_i;

    always_comb begin
        carry    = '0;
        term     = 1'b0;
        carry[0] = 1'b1;
        for (int i = 0; i < SIZE; i++) begin
            term = 1'b1;
            for (int j = 0; j <= i; j++) begin
                term = term & prop[j];
            end
            carry[i+1] = term;
            for (int j = 0; j <= i; j++) begin
                term = gen[j];
                for (int k = j + 1; k <= i; k++) begin
                    term = term & prop[k];
                end
                carry[i+1] = carry[i+1] | term;
            end
        end
    end

    assign diff_o      = prop ^ carry[SIZE-1:0];
    assign borrowOut_o = carry[SIZE];

endmodule

module restoring_divider_seq #(
    parameter int SIZE = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [SIZE-1:0] dividend,
    input  logic [SIZE-1:0] divisor,
    output logic            busy,
    output logic            done,
    output logic [SIZE-1:0] quotient,
    output logic [SIZE-1:0] remainder,
    output logic            div_by_zero
);

    localparam int CNT_W = $clog2(SIZE) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [SIZE:0]    rAcc_q, rAcc_d;
    logic [SIZE-1:0]  qShift_q, qShift_d;
    logic [SIZE:0]    dReg_q, dReg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             zFlag_q, zFlag_d;
    logic [SIZE-1:0]  quotient_q, quotient_d;
    logic [SIZE-1:0]  remainder_q, remainder_d;
    logic             divByZero_q, divByZero_d;
    logic             done_q, done_d;

    logic [SIZE:0]    trial;
    logic [SIZE:0]    diff;
    logic             noBorrow;

    assign trial = {rAcc_q[SIZE-1:0], qShift_q[SIZE-1]};

    subtractor_lookahead #(.SIZE(SIZE + 1)) u_sub (
        .a_i         (trial),
        .b_i         (dReg_q),
        .diff_o      (diff),
        .borrowOut_o (noBorrow)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rAcc_q      <= '0;
            qShift_q    <= '0;
            dReg_q      <= '0;
            cnt_q       <= '0;
            zFlag_q     <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            divByZero_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rAcc_q      <= rAcc_d;
            qShift_q    <= qShift_d;
            dReg_q      <= dReg_d;
            cnt_q       <= cnt_d;
            zFlag_q     <= zFlag_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            divByZero_q <= divByZero_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        rAcc_d      = rAcc_q;
        qShift_d    = qShift_q;
        dReg_d      = dReg_q;
        cnt_d       = cnt_q;
        zFlag_d     = zFlag_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        divByZero_d = divByZero_q;
        done_d      = 1'b0;

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d  = RUN;
                    rAcc_d   = '0;
                    qShift_d = dividend;
                    dReg_d   = {1'b0, divisor};
                    cnt_d    = '0;
                    zFlag_d  = (divisor == '0);
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
`ifdef DIV_ZERO_FAST_EN
                // The dividend is still unshifted here, so it is the natural remainder
                if (zFlag_q) begin
                    state_d     = DONE;
                    quotient_d  = '1;
                    remainder_d = qShift_q;
                    divByZero_d = 1'b1;
                    done_d      = 1'b1;
                end else
`endif
                begin
                    rAcc_d   = noBorrow ? diff : trial;
                    qShift_d = {qShift_q[SIZE-2:0], noBorrow};
                    cnt_d    = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(SIZE - 1)) begin
                        state_d     = DONE;
                        quotient_d  = qShift_d;
                        remainder_d = rAcc_d[SIZE-1:0];
                        divByZero_d = zFlag_q;
                        done_d      = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy        = (state_q == RUN);
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = divByZero_q;

endmodule
